banyan_sched_4x4: RTL and testbench

Round-robin scheduler that sits in front of the 4x4 banyan switch. It accepts one byte-wide request per input port, tagged with a 2-bit destination. Each cycle it grants a conflict-free subset, meaning no output contention and no internal stage-1 blocking, and drives the granted lanes into the switch's data_in/addr_in through registers. Requesters that are not granted hold their request and retry on a later cycle.

---
 rtl/banyan_pkg.sv | 34 +++
 rtl/banyan_grant_rr.sv | 56 +++++
 rtl/banyan_sched_4x4.sv | 120 ++++++++++++
 tb/tb_banyan_sched_4x4.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/banyan_pkg.sv
// banyan_pkg: shared constants, lane-slice helpers and the conflict predicate for the
// 4x4 banyan scheduler.
//   N_PORTS / ADDR_W : switch geometry (4 ports, 2-bit destinations).
//   lane_lo()        : low bit of lane i in a flat bus of w-bit lanes.
//   addr_lane()      : extract the 2-bit destination of one port from the flat address bus.
//   banyan_conflict(): 1 when two inputs cannot pass through the switch in the same cycle.
package banyan_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned PTR_W   = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PTR_W-1:0]  port_idx_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic addr_t addr_lane(input logic [N_PORTS*ADDR_W-1:0] addr_bus,
                                      input port_idx_t                 lane);
    return addr_bus[lane*ADDR_W +: ADDR_W];
  endfunction

  // Output contention, or two inputs of the same stage-1 element wanting the same
  // stage-1 output (addr bit 1 selects it). i[1] is the stage-1 element index.
  function automatic logic banyan_conflict(input port_idx_t i,
                                           input port_idx_t j,
                                           input addr_t     addr_i,
                                           input addr_t     addr_j);
    return (addr_i == addr_j) || ((i[1] == j[1]) && (addr_i[1] == addr_j[1]));
  endfunction

endpackage

// File: rtl/banyan_grant_rr.sv
// banyan_grant_rr: combinational round-robin priority walk for the banyan scheduler.
// Ports:
//   rr_ptr    in  2  highest-priority input this cycle
//   req_valid in  4  per-port request valid
//   req_addr  in  8  per-port destinations, lane i = bits [2i+1:2i]
//   grant     out 4  conflict-free grant vector
//   first_idx out 2  first granted index in priority order (valid when any_grant)
//   any_grant out 1  at least one input granted
module banyan_grant_rr
  import banyan_pkg::*;
(
  input  logic [PTR_W-1:0]          rr_ptr,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  output logic [N_PORTS-1:0]        grant,
  output logic [PTR_W-1:0]          first_idx,
  output logic                      any_grant
);

  logic [N_PORTS-1:0] gnt;
  port_idx_t          idx;
  port_idx_t          first;
  logic               found;
  logic               ok;

  always_comb begin
    gnt   = '0;
    first = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    ok    = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = rr_ptr + 2'(k);
      ok  = req_valid[idx];
      // Only inputs already granted earlier in the walk can block this one.
      for (int j = 0; j < N_PORTS; j++) begin
        if (gnt[j] && banyan_conflict(idx, 2'(j), addr_lane(req_addr, idx),
                                      addr_lane(req_addr, 2'(j)))) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        gnt[idx] = 1'b1;
        if (!found) begin
          found = 1'b1;
          first = idx;
        end
      end
    end
  end

  assign grant     = gnt;
  assign first_idx = first;
  assign any_grant = found;

endmodule

// File: rtl/banyan_sched_4x4.sv
// banyan_sched_4x4: round-robin scheduler in front of a 4x4 banyan switch. Grants a
// conflict-free subset of requests each cycle and registers the granted lanes toward the
// switch. Optional per-port blocked-cycle counters are built when BANYAN_STATS_EN is defined.
// Ports:
//   clk          in  1          rising-edge clock
//   rst          in  1          synchronous active-low reset
//   req_valid    in  4          per-port request valid
//   req_data     in  4*DATA_W   per-port payload, lane i = [i*DATA_W +: DATA_W]
//   req_addr     in  8          per-port destination, lane i = [2i+1:2i]
//   req_ready    out 4          combinational grant
//   stat_blocked out 4*STAT_W   blocked-cycle counters (BANYAN_STATS_EN only)
//   sw_valid     out 4          registered lane valid to the switch
//   sw_data      out 4*DATA_W   registered payload to switch data_in
//   sw_addr      out 8          registered destinations to switch addr_in
module banyan_sched_4x4
  import banyan_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*DATA_W-1:0] req_data,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  output logic [N_PORTS-1:0]        req_ready,
`ifdef BANYAN_STATS_EN
  output logic [N_PORTS*STAT_W-1:0] stat_blocked,
`endif
  output logic [N_PORTS-1:0]        sw_valid,
  output logic [N_PORTS*DATA_W-1:0] sw_data,
  output logic [N_PORTS*ADDR_W-1:0] sw_addr
);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0]        sw_valid_q, sw_valid_d;
  logic [N_PORTS*DATA_W-1:0] sw_data_q, sw_data_d;
  logic [N_PORTS*ADDR_W-1:0] sw_addr_q, sw_addr_d;

  logic [N_PORTS-1:0] grant_raw;
  logic [N_PORTS-1:0] grant;
  logic [PTR_W-1:0]   first_idx;
  logic               any_grant;

  banyan_grant_rr u_grant (
    .rr_ptr    (rr_ptr_q),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .grant     (grant_raw),
    .first_idx (first_idx),
    .any_grant (any_grant)
  );

  // No transfer may be signalled while reset is held.
  assign grant     = rst ? grant_raw : '0;
  assign req_ready = grant;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    sw_valid_d = grant;
    sw_data_d  = '0;
    sw_addr_d  = '0;
    if (any_grant) begin
      rr_ptr_d = first_idx + 2'd1;
    end
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        sw_data_d[lane_lo(i, DATA_W) +: DATA_W] = req_data[lane_lo(i, DATA_W) +: DATA_W];
        sw_addr_d[lane_lo(i, ADDR_W) +: ADDR_W] = req_addr[lane_lo(i, ADDR_W) +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      sw_valid_q <= '0;
      sw_data_q  <= '0;
      sw_addr_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      sw_valid_q <= sw_valid_d;
      sw_data_q  <= sw_data_d;
      sw_addr_q  <= sw_addr_d;
    end
  end

  assign sw_valid = sw_valid_q;
  assign sw_data  = sw_data_q;
  assign sw_addr  = sw_addr_q;

`ifdef BANYAN_STATS_EN
  logic [N_PORTS*STAT_W-1:0] stat_q, stat_d;

  // Saturating count of cycles a port was valid but not granted.
  always_comb begin
    stat_d = stat_q;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (req_valid[i] && !grant[i] && (stat_q[lane_lo(i, STAT_W) +: STAT_W] != '1)) begin
        stat_d[lane_lo(i, STAT_W) +: STAT_W] = stat_q[lane_lo(i, STAT_W) +: STAT_W]
                                               + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_blocked = stat_q;
`else
  logic [STAT_W-1:0] unused_stat_w;
  assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_banyan_sched_4x4.sv
// tb_banyan_sched_4x4: directed self-checking bench for banyan_sched_4x4.
module tb_banyan_sched_4x4;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  sw_valid;
  logic [31:0] sw_data;
  logic [7:0]  sw_addr;
`ifdef BANYAN_STATS_EN
  logic [4*STAT_W-1:0] stat_blocked;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banyan_sched_4x4 #(
    .DATA_W (DATA_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
`ifdef BANYAN_STATS_EN
    .stat_blocked (stat_blocked),
`endif
    .sw_valid     (sw_valid),
    .sw_data      (sw_data),
    .sw_addr      (sw_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] a,
                       input logic [31:0] d);
    rst       = r;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
  endtask

  // Contention sequence from rr_ptr = 0, all inputs to output 2.
  logic [3:0]  cont_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] cont_data [5] = '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000,
                                 32'h4400_0000, 32'h0000_0011};
  logic [7:0]  cont_addr [5] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};
  logic [1:0]  cont_ptr  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    // Reset held with all requests valid.
    drive(1'b0, 4'hF, 8'hD8, 32'h4433_2211);
    chk("rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("rst_sw_valid", 32'(sw_valid), 32'h0);
    chk("rst_sw_data", sw_data, 32'h0);
    chk("rst_sw_addr", 32'(sw_addr), 32'h0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // Output contention: one grant per cycle, rotating, wrapping 3 -> 0.
    drive(1'b1, 4'hF, 8'hAA, 32'h4433_2211);
    for (int e = 0; e < 5; e++) begin
      chk($sformatf("cont_ready_%0d", e), 32'(req_ready), 32'(cont_gnt[e]));
      step();
      chk($sformatf("cont_sw_valid_%0d", e), 32'(sw_valid), 32'(cont_gnt[e]));
      chk($sformatf("cont_sw_data_%0d", e), sw_data, cont_data[e]);
      chk($sformatf("cont_sw_addr_%0d", e), 32'(sw_addr), 32'(cont_addr[e]));
      chk($sformatf("cont_ptr_%0d", e), 32'(dut.rr_ptr_q), 32'(cont_ptr[e]));
    end

    // Permutation 0,2,1,3: all four pass; rr_ptr 1 -> 2.
    drive(1'b1, 4'hF, 8'hD8, 32'hDDCC_BBAA);
    chk("perm_ready", 32'(req_ready), 32'hF);
    step();
    chk("perm_sw_valid", 32'(sw_valid), 32'hF);
    chk("perm_sw_data", sw_data, 32'hDDCC_BBAA);
    chk("perm_sw_addr", 32'(sw_addr), 32'hD8);
    chk("perm_ptr", 32'(dut.rr_ptr_q), 32'h2);

    // Mixed from rr_ptr 2: in3 collides with in2 at output 3.
    drive(1'b1, 4'hF, 8'hF9, 32'hA4A3_A2A1);
    chk("mixed_ready", 32'(req_ready), 32'h7);
    step();
    chk("mixed_sw_valid", 32'(sw_valid), 32'h7);
    chk("mixed_sw_data", sw_data, 32'h00A3_A2A1);
    chk("mixed_sw_addr", 32'(sw_addr), 32'h39);
    chk("mixed_ptr", 32'(dut.rr_ptr_q), 32'h3);

    // Single request on in3 moves the pointer around to 0.
    drive(1'b1, 4'h8, 8'hC0, 32'h5A00_0000);
    chk("single_ready", 32'(req_ready), 32'h8);
    step();
    chk("single_sw_data", sw_data, 32'h5A00_0000);
    chk("single_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // Internal blocking: in0 (addr 0) and in1 (addr 1) share stage-1 upper output.
    drive(1'b1, 4'h3, 8'h04, 32'h0000_B2B1);
    chk("block_ready0", 32'(req_ready), 32'h1);
    step();
    chk("block_sw_valid0", 32'(sw_valid), 32'h1);
    chk("block_sw_data0", sw_data, 32'h0000_00B1);
    chk("block_sw_addr0", 32'(sw_addr), 32'h00);
    chk("block_ptr0", 32'(dut.rr_ptr_q), 32'h1);
    drive(1'b1, 4'h2, 8'h04, 32'h0000_B2B1);
    chk("block_ready1", 32'(req_ready), 32'h2);
    step();
    chk("block_sw_valid1", 32'(sw_valid), 32'h2);
    chk("block_sw_data1", sw_data, 32'h0000_B200);
    chk("block_sw_addr1", 32'(sw_addr), 32'h04);
    chk("block_ptr1", 32'(dut.rr_ptr_q), 32'h2);

    // Idle: nothing granted, pointer holds.
    drive(1'b1, 4'h0, 8'h04, 32'h0000_B2B1);
    chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("idle_sw_valid", 32'(sw_valid), 32'h0);
    chk("idle_sw_data", sw_data, 32'h0);
    chk("idle_ptr", 32'(dut.rr_ptr_q), 32'h2);

    // Reset mid-stream discards the grant of that cycle.
    drive(1'b1, 4'hF, 8'hD8, 32'hDDCC_BBAA);
    chk("mid_ready_pre", 32'(req_ready), 32'hF);
    drive(1'b0, 4'hF, 8'hD8, 32'hDDCC_BBAA);
    chk("mid_ready_rst", 32'(req_ready), 32'h0);
    step();
    chk("mid_sw_valid", 32'(sw_valid), 32'h0);
    chk("mid_ptr", 32'(dut.rr_ptr_q), 32'h0);
    drive(1'b1, 4'hF, 8'hD8, 32'hDDCC_BBAA);
    chk("post_rst_ready", 32'(req_ready), 32'hF);
    step();
    chk("post_rst_sw_valid", 32'(sw_valid), 32'hF);
    chk("post_rst_sw_data", sw_data, 32'hDDCC_BBAA);

`ifdef BANYAN_STATS_EN
    // Contention for 8 cycles: each port granted twice, blocked six times.
    drive(1'b0, 4'h0, 8'h00, 32'h0);
    step();
    drive(1'b1, 4'hF, 8'hAA, 32'h4433_2211);
    for (int c = 0; c < 8; c++) step();
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("stat_lane_%0d", l), 32'(stat_blocked[l*STAT_W +: STAT_W]), 32'd6);
    end
    force dut.stat_q = '1;
    step();
    release dut.stat_q;
    step();
    step();
    chk("stat_saturate", 32'(stat_blocked[15:0]), 32'h0000_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
